// File: rtl/std_8b10b_pkg.sv
// Shared 8b10b receive-path definitions: sync state encoding, comma patterns and K28.5 code groups.
package std_8b10b_pkg;

  typedef enum logic [1:0] {
    SYNC_LOSS      = 2'd0,
    SYNC_SLIP_WAIT = 2'd1,
    SYNC_COMMA_DET = 2'd2,
    SYNC_ACQ       = 2'd3
  } sync_state_e;

  // Comma patterns as seen on code group bits [9:3] (a..g)
  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  localparam logic [9:0] K28_5_RDN  = 10'h0FA;
  localparam logic [9:0] K28_5_RDP  = 10'h305;
  localparam logic [7:0] K28_5_DATA = 8'hBC;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/std_8b10b_comma_detect.sv
// Comma match on the raw code group, delayed DEC_LAT cycles so the flag lines up with the decoder outputs.
module std_8b10b_comma_detect
  import std_8b10b_pkg::*;
#(
  parameter int unsigned DEC_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] code_group,
  output logic       comma_aligned
);

  logic               comma_c;
  logic [DEC_LAT-1:0] dly;
  logic [2:0]         code_group_unused;

  assign comma_c = (code_group[9:3] == COMMA_P) || (code_group[9:3] == COMMA_N);
  assign code_group_unused = code_group[2:0];

  // Cleared delay line masks detection until it has refilled after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      dly <= '0;
    end else begin
      dly[0] <= comma_c;
      for (int i = 1; i < int'(DEC_LAT); i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign comma_aligned = dly[DEC_LAT-1];

endmodule

// File: rtl/std_8b10b_sync_ctrl.sv
// Word-sync controller for the 8b10b receive path: comma acquisition, error-level tracking and bitslip requests.
// Build option: define STD_8B10B_SYNC_DISP_ERR_EN to treat decoder disparity errors as invalid code groups.
module std_8b10b_sync_ctrl
  import std_8b10b_pkg::*;
#(
  parameter int unsigned DEC_LAT      = 2,
  parameter int unsigned COMMA_CNT    = 3,
  parameter int unsigned ERR_CNT_MAX  = 4,
  parameter int unsigned GOOD_CGS     = 4,
  parameter int unsigned SLIP_TIMEOUT = 32,
  parameter int unsigned SLIP_WAIT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] rx_code_group,
  input  logic       dec_k,
  input  logic [7:0] dec_data,
  input  logic       dec_code_err,
  input  logic       dec_disp_err,
  output logic       bitslip,
  output logic       sync_ok,
  output logic [1:0] sync_state,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_k,
  output logic [2:0] err_level
);

  localparam int unsigned TMR_W  = cnt_width(SLIP_TIMEOUT);
  localparam int unsigned WAIT_W = cnt_width(SLIP_WAIT);
  localparam int unsigned CMA_W  = cnt_width(COMMA_CNT);
  localparam int unsigned GOOD_W = cnt_width(GOOD_CGS);
  localparam int unsigned ERR_W  = 3;

  localparam logic [1:0] ST_LOSS      = SYNC_LOSS;
  localparam logic [1:0] ST_SLIP_WAIT = SYNC_SLIP_WAIT;
  localparam logic [1:0] ST_COMMA_DET = SYNC_COMMA_DET;
  localparam logic [1:0] ST_SYNC_ACQ  = SYNC_ACQ;

  logic [1:0]        state, state_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [CMA_W-1:0]  comma_cnt, comma_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [ERR_W-1:0]  err_q, err_nxt;
  logic              slip_nxt;
  logic              sync_ok_nxt;
  logic              rx_valid_nxt;
  logic              comma_aligned;
  logic              invalid_c;

  std_8b10b_comma_detect #(
    .DEC_LAT(DEC_LAT)
  ) u_comma_detect (
    .clk          (clk),
    .reset        (reset),
    .code_group   (rx_code_group),
    .comma_aligned(comma_aligned)
  );

`ifdef STD_8B10B_SYNC_DISP_ERR_EN
  assign invalid_c = dec_code_err | dec_disp_err;
`else
  logic disp_err_unused;
  assign disp_err_unused = dec_disp_err;
  assign invalid_c       = dec_code_err;
`endif

  // Next-state and counter update; invalid code groups win over commas
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    wait_nxt  = wait_cnt;
    comma_nxt = comma_cnt;
    good_nxt  = good_cnt;
    err_nxt   = err_q;
    slip_nxt  = 1'b0;

    case (state)
      ST_LOSS: begin
        if (comma_aligned && !invalid_c) begin
          state_nxt = ST_COMMA_DET;
          comma_nxt = CMA_W'(1);
          timer_nxt = '0;
        end else if (timer == TMR_W'(SLIP_TIMEOUT - 1)) begin
          state_nxt = ST_SLIP_WAIT;
          slip_nxt  = 1'b1;
          timer_nxt = '0;
          wait_nxt  = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end

      ST_SLIP_WAIT: begin
        if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
          state_nxt = ST_LOSS;
          wait_nxt  = '0;
          timer_nxt = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end

      ST_COMMA_DET: begin
        if (invalid_c) begin
          state_nxt = ST_LOSS;
          comma_nxt = '0;
          timer_nxt = '0;
        end else if (comma_aligned) begin
          if (comma_cnt == CMA_W'(COMMA_CNT - 1)) begin
            state_nxt = ST_SYNC_ACQ;
            comma_nxt = '0;
            err_nxt   = '0;
            good_nxt  = '0;
          end else begin
            comma_nxt = comma_cnt + CMA_W'(1);
          end
        end
      end

      ST_SYNC_ACQ: begin
        if (invalid_c) begin
          good_nxt = '0;
          if (err_q >= ERR_W'(ERR_CNT_MAX - 1)) begin
            err_nxt   = ERR_W'(ERR_CNT_MAX);
            state_nxt = ST_LOSS;
            timer_nxt = '0;
          end else begin
            err_nxt = err_q + ERR_W'(1);
          end
        end else if (err_q != '0) begin
          if (good_cnt == GOOD_W'(GOOD_CGS - 1)) begin
            err_nxt  = err_q - ERR_W'(1);
            good_nxt = '0;
          end else begin
            good_nxt = good_cnt + GOOD_W'(1);
          end
        end else begin
          good_nxt = '0;
        end
      end

      default: begin
        state_nxt = ST_LOSS;
        timer_nxt = '0;
      end
    endcase

    sync_ok_nxt  = (state_nxt == ST_SYNC_ACQ);
    rx_valid_nxt = (state == ST_SYNC_ACQ) && !invalid_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOSS;
      timer     <= '0;
      wait_cnt  <= '0;
      comma_cnt <= '0;
      good_cnt  <= '0;
      err_q     <= '0;
      bitslip   <= 1'b0;
      sync_ok   <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_k      <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      wait_cnt  <= wait_nxt;
      comma_cnt <= comma_nxt;
      good_cnt  <= good_nxt;
      err_q     <= err_nxt;
      bitslip   <= slip_nxt;
      sync_ok   <= sync_ok_nxt;
      rx_valid  <= rx_valid_nxt;
      rx_data   <= dec_data;
      rx_k      <= dec_k;
    end
  end

  assign sync_state = state;
  assign err_level  = err_q;

endmodule

// File: tb/tb_std_8b10b_sync_ctrl.sv
// Scoreboard bench for std_8b10b_sync_ctrl: behavioural reference plus directed checks of acquisition, slip and error tracking.
// Honors STD_8B10B_SYNC_DISP_ERR_EN the same way the design does.
module tb_std_8b10b_sync_ctrl;
  import std_8b10b_pkg::*;

  localparam int DEC_LAT      = 2;
  localparam int COMMA_CNT    = 3;
  localparam int ERR_CNT_MAX  = 4;
  localparam int GOOD_CGS     = 4;
  localparam int SLIP_TIMEOUT = 32;
  localparam int SLIP_WAIT    = 16;
`ifdef STD_8B10B_SYNC_DISP_ERR_EN
  localparam bit DISP_EN = 1'b1;
`else
  localparam bit DISP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] rx_code_group = '0;
  logic       dec_k = 1'b0;
  logic [7:0] dec_data = '0;
  logic       dec_code_err = 1'b0;
  logic       dec_disp_err = 1'b0;
  logic       bitslip;
  logic       sync_ok;
  logic [1:0] sync_state;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_k;
  logic [2:0] err_level;

  typedef struct packed {
    logic       bitslip;
    logic       sync_ok;
    logic [1:0] state;
    logic       rx_valid;
    logic [7:0] data;
    logic       k;
    logic [2:0] err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [9:0] p1 = '0;
  logic [9:0] p2 = '0;

  // Reference model state
  int   m_state = 0, m_timer = 0, m_wait = 0, m_commas = 0, m_err = 0, m_good = 0;
  bit   m_cd0 = 0, m_cd1 = 0;
  exp_t m_out = '0;

  std_8b10b_sync_ctrl #(
    .DEC_LAT     (DEC_LAT),
    .COMMA_CNT   (COMMA_CNT),
    .ERR_CNT_MAX (ERR_CNT_MAX),
    .GOOD_CGS    (GOOD_CGS),
    .SLIP_TIMEOUT(SLIP_TIMEOUT),
    .SLIP_WAIT   (SLIP_WAIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_code_group(rx_code_group),
    .dec_k        (dec_k),
    .dec_data     (dec_data),
    .dec_code_err (dec_code_err),
    .dec_disp_err (dec_disp_err),
    .bitslip      (bitslip),
    .sync_ok      (sync_ok),
    .sync_state   (sync_state),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_k         (rx_k),
    .err_level    (err_level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_comma(input logic [9:0] cg);
    logic [6:0] top;
    top = cg[9:3];
    return (top == COMMA_P) || (top == COMMA_N);
  endfunction

  function automatic void decode(input logic [9:0] cg, output logic k, output logic [7:0] d);
    if (cg == K28_5_RDN || cg == K28_5_RDP) begin
      k = 1'b1; d = K28_5_DATA;
    end else if (cg == 10'h2AA) begin
      k = 1'b0; d = 8'hB5;
    end else begin
      k = 1'b0; d = cg[7:0];
    end
  endfunction

  // Expected outputs after the coming edge, from the behaviour described for the block
  task automatic model_step(input logic rst, input logic [9:0] cg, input logic cerr, input logic derr,
                            input logic dk, input logic [7:0] dd);
    bit ca, inv;
    if (rst) begin
      m_state = 0; m_timer = 0; m_wait = 0; m_commas = 0; m_err = 0; m_good = 0;
      m_cd0 = 0; m_cd1 = 0; m_out = '0;
      return;
    end
    ca  = m_cd1;
    inv = cerr || (DISP_EN && derr);
    m_out.bitslip  = 1'b0;
    m_out.rx_valid = (m_state == 3) && !inv;
    m_out.data     = dd;
    m_out.k        = dk;
    if (m_state == 0) begin
      if (ca && !inv) begin
        m_state = 2; m_commas = 1; m_timer = 0;
      end else if (m_timer == SLIP_TIMEOUT - 1) begin
        m_state = 1; m_timer = 0; m_wait = 0; m_out.bitslip = 1'b1;
      end else m_timer++;
    end else if (m_state == 1) begin
      if (m_wait == SLIP_WAIT - 1) begin
        m_state = 0; m_wait = 0; m_timer = 0;
      end else m_wait++;
    end else if (m_state == 2) begin
      if (inv) begin
        m_state = 0; m_commas = 0; m_timer = 0;
      end else if (ca) begin
        m_commas++;
        if (m_commas == COMMA_CNT) begin
          m_state = 3; m_commas = 0; m_err = 0; m_good = 0;
        end
      end
    end else begin
      if (inv) begin
        m_good = 0;
        m_err++;
        if (m_err >= ERR_CNT_MAX) begin
          m_err = ERR_CNT_MAX; m_state = 0; m_timer = 0;
        end
      end else if (m_err > 0) begin
        m_good++;
        if (m_good == GOOD_CGS) begin
          m_err--; m_good = 0;
        end
      end
    end
    m_cd1 = m_cd0;
    m_cd0 = is_comma(cg);
    m_out.sync_ok = (m_state == 3);
    m_out.state   = 2'(m_state);
    m_out.err     = 3'(m_err);
  endtask

  // One cycle: drive at negedge, predict, compare #1 after the posedge
  task automatic drive_cycle(input logic rst, input logic [9:0] cg, input logic cerr, input logic derr);
    logic       dk;
    logic [7:0] dd;
    exp_t       e;
    @(negedge clk);
    decode(p2, dk, dd);
    reset = rst; rx_code_group = cg; dec_k = dk; dec_data = dd;
    dec_code_err = cerr; dec_disp_err = derr;
    p2 = p1; p1 = cg;
    model_step(rst, cg, cerr, derr, dk, dd);
    sb_q.push_back(m_out);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check($sformatf("sb_bitslip@%0d", cyc), 32'(bitslip), 32'(e.bitslip));
    check($sformatf("sb_sync_ok@%0d", cyc), 32'(sync_ok), 32'(e.sync_ok));
    check($sformatf("sb_state@%0d", cyc), 32'(sync_state), 32'(e.state));
    check($sformatf("sb_rx_valid@%0d", cyc), 32'(rx_valid), 32'(e.rx_valid));
    check($sformatf("sb_rx_data@%0d", cyc), 32'(rx_data), 32'(e.data));
    check($sformatf("sb_rx_k@%0d", cyc), 32'(rx_k), 32'(e.k));
    check($sformatf("sb_err@%0d", cyc), 32'(err_level), 32'(e.err));
    cyc++;
  endtask

  task automatic acquire(input string tag);
    int n = 0;
    while (!sync_ok && n < 40) begin
      drive_cycle(1'b0, (n % 2 == 0) ? K28_5_RDN : K28_5_RDP, 1'b0, 1'b0);
      n++;
    end
    check(tag, 32'(sync_ok), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bitslip"}, 32'(bitslip), 32'd0);
    check({tag, "_sync_ok"}, 32'(sync_ok), 32'd0);
    check({tag, "_state"}, 32'(sync_state), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_k"}, 32'(rx_k), 32'd0);
    check({tag, "_err"}, 32'(err_level), 32'd0);
  endtask

  initial begin
    int first_sync, slip1, slip2, n_wait, n_slips;
    bit prev_slip, dbl;

    drive_cycle(1'b1, 10'h000, 1'b0, 1'b0);
    drive_cycle(1'b1, 10'h000, 1'b0, 1'b0);
    check_reset_values("rst");

    // Acquisition on alternating-disparity K28.5
    first_sync = -1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, (i % 2 == 0) ? K28_5_RDN : K28_5_RDP, 1'b0, 1'b0);
      if (sync_ok && first_sync < 0) first_sync = i;
    end
    check("acq_cycle", 32'(first_sync), 32'd4);
    check("acq_rx_valid", 32'(rx_valid), 32'd1);
    check("acq_rx_data", 32'(rx_data), 32'hBC);
    check("acq_rx_k", 32'(rx_k), 32'd1);

    // Four consecutive code errors lose sync
    drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b0);
    drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 10'h2AA, 1'b1, 1'b0);
      check($sformatf("err_seq%0d", i), 32'(err_level), 32'(i + 1));
      check($sformatf("err_sync%0d", i), 32'(sync_ok), (i < 3) ? 32'd1 : 32'd0);
    end
    check("loss_rx_valid", 32'(rx_valid), 32'd0);
    check("loss_state", 32'(sync_state), 32'd0);

    // No commas in LOSS: periodic bitslip with settle window
    slip1 = -1; slip2 = -1; n_wait = 0; n_slips = 0; prev_slip = 0; dbl = 0;
    for (int i = 1; i <= 85; i++) begin
      drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b0);
      if (bitslip) begin
        n_slips++;
        if (slip1 < 0) slip1 = i;
        else if (slip2 < 0) slip2 = i;
        if (prev_slip) dbl = 1;
      end
      prev_slip = bitslip;
      if (sync_state == 2'd1 && i < 80) n_wait++;
    end
    check("slip1_cycle", 32'(slip1), 32'd32);
    check("slip2_cycle", 32'(slip2), 32'd80);
    check("slip_wait_len", 32'(n_wait), 32'd16);
    check("slip_count", 32'(n_slips), 32'd2);
    check("slip_back2back", 32'(dbl), 32'd0);

    // 1 error + 4 good keeps toggling the error level
    acquire("reacq1");
    drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b0);
    drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 5; j++) begin
        drive_cycle(1'b0, 10'h2AA, (j == 0) ? 1'b1 : 1'b0, 1'b0);
        check($sformatf("tog_err%0d_%0d", r, j), 32'(err_level), (j == 4) ? 32'd0 : 32'd1);
        check($sformatf("tog_sync%0d_%0d", r, j), 32'(sync_ok), 32'd1);
      end
    end

    // Disparity errors count only when the option is built in
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b1);
    check("disp_sync_ok", 32'(sync_ok), DISP_EN ? 32'd0 : 32'd1);
    check("disp_err", 32'(err_level), DISP_EN ? 32'd4 : 32'd0);

    // Reset mid-sync with err_level 2
    acquire("reacq2");
    drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b0);
    drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b0);
    drive_cycle(1'b0, 10'h2AA, 1'b1, 1'b0);
    drive_cycle(1'b0, 10'h2AA, 1'b1, 1'b0);
    check("pre_rst_err", 32'(err_level), 32'd2);
    check("pre_rst_sync", 32'(sync_ok), 32'd1);
    drive_cycle(1'b1, 10'h2AA, 1'b0, 1'b0);
    check_reset_values("midrst");

    // Reset on the cycle that would have issued a bitslip
    for (int i = 0; i < 31; i++) drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b0);
    drive_cycle(1'b1, 10'h2AA, 1'b0, 1'b0);
    check("rst_kills_slip", 32'(bitslip), 32'd0);
    check("rst_kills_slip_state", 32'(sync_state), 32'd0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 10'h2AA, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
